sd_cmd_sequencer: RTL and testbench

Sequences one SD-card SPI command transaction on behalf of the memory-mapped SD command register. On a rising edge of `start` it frames the command with chip select, shifts the 48-bit command out byte-by-byte through the SPI byte engine and polls for the R1 response, with a bounded timeout. It then publishes the response byte and flips a change-indicator toggle, which the memory map latches into its response buffer. It sits between the memory map (`cmd`/`start`/`response`/`response_toggle`) and `spi_byte_engine` (byte handshake, `cs_n`).

---
 rtl/sd_pkg.sv | 23 ++
 rtl/sd_cmd_sequencer_if.sv | 27 ++
 rtl/rise_detect.sv | 21 ++
 rtl/sd_cmd_sequencer.sv | 121 ++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD command sequencer.
// Covers the sequencer states, SPI fill byte and R1 response layout.
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    SEND = 3'd2,
    POLL = 3'd3,
    POST = 3'd4,
    DONE = 3'd5
  } sd_state_t;

  localparam logic [7:0] SD_FILL_BYTE   = 8'hFF;
  localparam int         SD_CMD_BYTES   = 6;
  localparam int         SD_R1_BUSY_BIT = 7;

  // Byte idx of the 48-bit frame, most significant byte first.
  function automatic logic [7:0] sd_cmd_byte(input logic [47:0] frame, input logic [2:0] idx);
    return frame[47 - 8*int'(idx) -: 8];
  endfunction

endpackage

// File: rtl/sd_cmd_sequencer_if.sv
// Byte-level handshake between the command sequencer and the SPI byte engine.
// The master side drives chip select and byte requests; the engine answers with done/rx data.
interface sd_cmd_sequencer_if;

  logic       cs_n;
  logic [7:0] spi_tx_data;
  logic       spi_tx_start;
  logic [7:0] spi_rx_data;
  logic       spi_done;

  modport master (
    output cs_n,
    output spi_tx_data,
    output spi_tx_start,
    input  spi_rx_data,
    input  spi_done
  );

  modport slave (
    input  cs_n,
    input  spi_tx_data,
    input  spi_tx_start,
    output spi_rx_data,
    output spi_done
  );

endinterface

// File: rtl/rise_detect.sv
// Registered 0->1 edge detector: pulse is high for one cycle after d is first seen high.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q   <= 1'b0;
      pulse <= 1'b0;
    end else begin
      d_q   <= d;
      pulse <= d & ~d_q;
    end
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Runs one SD SPI command transaction: fill byte, 6 command bytes, R1 poll, trailing fill byte.
// Publishes the R1 byte (or FF on timeout) and flips response_toggle once per completion.
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter int TIMEOUT_BYTES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [47:0]         cmd,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [7:0]          response,
  output logic                response_toggle,
  output logic                timeout,
  sd_cmd_sequencer_if.master  spi
);

  localparam int              PW        = $clog2(TIMEOUT_BYTES + 1);
  localparam logic [2:0]      LAST_IDX  = 3'(SD_CMD_BYTES - 1);
  localparam logic [PW-1:0]   POLL_LAST = PW'(TIMEOUT_BYTES - 1);

  sd_state_t     state, next_state;
  logic          start_edge;
  logic          launch;
  logic          byte_state;
  logic          r1_seen;
  logic          tx_req;
  logic [47:0]   cmd_q;
  logic [2:0]    byte_idx;
  logic [PW-1:0] poll_cnt;

  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .d     (start),
    .pulse (start_edge)
  );

  assign launch     = start_edge && (state == IDLE);
  assign byte_state = (state == PRE) || (state == SEND) || (state == POLL) || (state == POST);
  assign r1_seen    = ~spi.spi_rx_data[SD_R1_BUSY_BIT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start_edge) next_state = PRE;
      PRE:  if (spi.spi_done) next_state = SEND;
      SEND: if (spi.spi_done && byte_idx == LAST_IDX) next_state = POLL;
      POLL: if (spi.spi_done && (r1_seen || poll_cnt == POLL_LAST)) next_state = POST;
      POST: if (spi.spi_done) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // cs_n is decoded from state so an async reset releases the card immediately.
  always_comb begin
    spi.cs_n         = ~byte_state;
    spi.spi_tx_start = tx_req;
    spi.spi_tx_data  = (state == SEND) ? sd_cmd_byte(cmd_q, byte_idx) : SD_FILL_BYTE;
    busy             = byte_state;
    done             = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q           <= '0;
      byte_idx        <= '0;
      poll_cnt        <= '0;
      response        <= SD_FILL_BYTE;
      timeout         <= 1'b0;
      response_toggle <= 1'b0;
      tx_req          <= 1'b0;
    end else begin
      // Next byte is requested only once the previous exchange has completed.
      tx_req <= launch || (spi.spi_done && byte_state && next_state != DONE);
      unique case (state)
        IDLE: begin
          if (start_edge) begin
            cmd_q   <= cmd;
            timeout <= 1'b0;
          end
        end
        PRE: begin
          if (spi.spi_done) byte_idx <= '0;
        end
        SEND: begin
          if (spi.spi_done) begin
            if (byte_idx == LAST_IDX) poll_cnt <= '0;
            else                      byte_idx <= byte_idx + 3'd1;
          end
        end
        POLL: begin
          if (spi.spi_done) begin
            if (r1_seen) begin
              response <= spi.spi_rx_data;
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
              if (poll_cnt == POLL_LAST) begin
                response <= SD_FILL_BYTE;
                timeout  <= 1'b1;
              end
            end
          end
        end
        POST: begin
          if (spi.spi_done) response_toggle <= ~response_toggle;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Bench for sd_cmd_sequencer: behavioural SPI byte engine, tx-byte scoreboard,
// table of full transactions plus hand sequences for start, reset and idle-done corners.
module tb_sd_cmd_sequencer;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [47:0] cmd;
  logic        busy, done, response_toggle, timeout;
  logic [7:0]  response;

  always #5 clk = ~clk;

  sd_cmd_sequencer_if sif();

  sd_cmd_sequencer #(.TIMEOUT_BYTES(TO)) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd             (cmd),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .response        (response),
    .response_toggle (response_toggle),
    .timeout         (timeout),
    .spi             (sif)
  );

  typedef struct {
    logic [47:0] c;
    int          nff;
    logic [7:0]  r1;
    logic [7:0]  er;
    bit          eto;
    int          polls;
  } vec_t;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  int         eng_idx = 0, eng_total = 0, eng_nff = 0, pend = 0, overlap = 0, done_cnt = 0;
  logic [7:0] eng_r1 = 8'h00, eng_rx = 8'hFF;
  bit         eng_inj = 1'b0;
  bit         exp_tog = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SPI byte engine: two idle cycles per exchange, then a one-cycle done with the scripted rx byte.
  initial begin
    sif.spi_done    = 1'b0;
    sif.spi_rx_data = 8'hFF;
    forever begin
      @(posedge clk); #1;
      if (sif.spi_done) begin
        sif.spi_done    = 1'b0;
        sif.spi_rx_data = 8'hFF;
      end
      if (pend > 0) begin
        if (sif.spi_tx_start) overlap++;
        pend--;
        if (pend == 0) begin
          sif.spi_rx_data = eng_rx;
          sif.spi_done    = 1'b1;
        end
      end else begin
        if (sif.cs_n) eng_idx = 0;
        if (eng_inj) begin
          eng_inj         = 1'b0;
          sif.spi_rx_data = 8'h00;
          sif.spi_done    = 1'b1;
        end else if (sif.spi_tx_start) begin
          check($sformatf("cs_low_at_tx%0d", eng_idx), sif.cs_n, 1'b0);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_byte%0d: got %02h but no byte expected", eng_idx, sif.spi_tx_data);
          end else begin
            check($sformatf("tx_byte%0d", eng_idx), sif.spi_tx_data, exp_q.pop_front());
          end
          eng_rx = (eng_idx == 7 + eng_nff) ? eng_r1 : 8'hFF;
          eng_idx++;
          eng_total++;
          pend = 2;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (done) done_cnt++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push_header(input logic [47:0] c);
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 6; i++) exp_q.push_back(c[47 - 8*i -: 8]);
  endtask

  task automatic push_frame(input logic [47:0] c, input int polls);
    push_header(c);
    for (int i = 0; i < polls; i++) exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
  endtask

  task automatic wait_idx(input int n);
    bit got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (eng_idx >= n) begin got = 1'b1; break; end
    end
    check($sformatf("reach_byte%0d", n), got, 1'b1);
  endtask

  // mode 0: plain; mode 1: hold start and re-pulse it mid-SEND; mode 2: change cmd mid-SEND.
  task automatic run_txn(input vec_t v, input int mode, input logic [47:0] alt);
    int base_total, base_done;
    bit got;
    eng_nff = v.nff;
    eng_r1  = v.r1;
    push_frame(v.c, v.polls);
    base_total = eng_total;
    base_done  = done_cnt;
    cmd = v.c;
    @(posedge clk); #1;
    start = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!sif.cs_n) begin got = 1'b1; break; end
    end
    check("launch", got, 1'b1);
    check("busy_launch", busy, 1'b1);
    check("timeout_cleared", timeout, 1'b0);
    if (mode == 1) begin
      wait_idx(4);
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
    end
    if (mode == 2) begin
      wait_idx(3);
      cmd = alt;
    end
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (done) begin got = 1'b1; break; end
    end
    check("done_seen", got, 1'b1);
    exp_tog = ~exp_tog;
    check("response", response, v.er);
    check("timeout", timeout, v.eto);
    check("toggle", response_toggle, exp_tog);
    check("cs_n_at_done", sif.cs_n, 1'b1);
    check("busy_at_done", busy, 1'b0);
    #1;
    check("done_once", done_cnt - base_done, 1);
    check("tx_count", eng_total - base_total, 8 + v.polls);
    check("queue_empty", exp_q.size(), 0);
    check("no_overlap", overlap, 0);
    if (mode != 1) start = 1'b0;
  endtask

  vec_t vecs[4];
  vec_t vx;
  int   base_total, base_done;

  initial begin
    vecs[0] = '{c: 48'h40_0000_0000_95, nff: 2,   r1: 8'h01, er: 8'h01, eto: 1'b0, polls: 3};
    vecs[1] = '{c: 48'h48_0000_01AA_87, nff: 255, r1: 8'h00, er: 8'hFF, eto: 1'b1, polls: 16};
    vecs[2] = '{c: 48'h51_1234_5678_FF, nff: 0,   r1: 8'h05, er: 8'h05, eto: 1'b0, polls: 1};
    vecs[3] = '{c: 48'h77_0000_0000_65, nff: 15,  r1: 8'h00, er: 8'h00, eto: 1'b0, polls: 16};

    reset = 1'b1;
    start = 1'b0;
    cmd   = '0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_response", response, 8'hFF);
    check("rst_toggle", response_toggle, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_cs_n", sif.cs_n, 1'b1);
    check("rst_tx_start", sif.spi_tx_start, 1'b0);
    check("rst_tx_data", sif.spi_tx_data, 8'hFF);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 4; i++) begin
      run_txn(vecs[i], 0, 48'h0);
      repeat (3) @(posedge clk);
    end

    // start held through completion with an extra pulse mid-SEND: exactly one transaction
    vx = '{c: 48'h41_0000_0000_F9, nff: 1, r1: 8'h00, er: 8'h00, eto: 1'b0, polls: 2};
    run_txn(vx, 1, 48'h0);
    base_total = eng_total;
    base_done  = done_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("no_relaunch_tx", eng_total - base_total, 0);
    check("no_relaunch_done", done_cnt - base_done, 0);
    start = 1'b0;
    repeat (2) @(posedge clk);
    vx = '{c: 48'h4D_0000_0000_0D, nff: 0, r1: 8'h02, er: 8'h02, eto: 1'b0, polls: 1};
    run_txn(vx, 0, 48'h0);
    repeat (2) @(posedge clk);

    // done pulses while idle must not move the sequencer or the response
    base_done = done_cnt;
    for (int i = 0; i < 3; i++) begin
      eng_inj = 1'b1;
      repeat (3) @(posedge clk);
    end
    #1;
    check("idle_busy", busy, 1'b0);
    check("idle_cs_n", sif.cs_n, 1'b1);
    check("idle_response", response, 8'h02);
    check("idle_toggle", response_toggle, exp_tog);
    check("idle_done_cnt", done_cnt - base_done, 0);

    // cmd changed after launch: frame must still match the launched cmd
    vx = '{c: 48'h58_DEAD_BEEF_C3, nff: 1, r1: 8'h04, er: 8'h04, eto: 1'b0, polls: 2};
    run_txn(vx, 2, 48'h11_2233_4455_67);
    repeat (2) @(posedge clk);

    // asynchronous reset during SEND byte 3, with the engine's done arriving afterwards
    eng_nff = 255;
    push_header(48'h6A_0102_0304_05);
    cmd = 48'h6A_0102_0304_05;
    @(posedge clk); #1;
    start = 1'b1;
    wait_idx(5);
    #1;
    reset = 1'b1;
    #1;
    check("arst_cs_n", sif.cs_n, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_response", response, 8'hFF);
    check("arst_tx_start", sif.spi_tx_start, 1'b0);
    check("arst_toggle", response_toggle, 1'b0);
    exp_q.delete();
    exp_tog = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    base_done = done_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_cs_n", sif.cs_n, 1'b1);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_done", done_cnt - base_done, 0);
    check("post_rst_response", response, 8'hFF);
    vx = '{c: 48'h6A_0102_0304_05, nff: 3, r1: 8'h00, er: 8'h00, eto: 1'b0, polls: 4};
    run_txn(vx, 0, 48'h0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
